// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: round-robin grant of three result sources
// (ALU, load data, link PC) onto a shared register-file write port, with
// an owner lock bounded by MAX_HOLD whenever another source is waiting.
module wb_port_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] lock,
  output logic [2:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic [3:0] hold_cnt
);

  localparam logic [3:0] MAXH = 4'(MAX_HOLD);

  typedef enum logic {IDLE, OWN} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [2:0] grant_nxt;
  logic [1:0] sel_nxt;
  logic       busy_nxt;
  logic [3:0] hold_nxt;

  logic       keep;
  logic [2:0] others;
  logic [1:0] scan_ptr;
  logic [1:0] cand;
  logic [3:0] req_ext;
  logic       win_any;
  logic [1:0] win_idx;
  logic [2:0] win_oh;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Keep decision for the current owner; on release the scan starts just past the owner.
  always_comb begin
    others   = req & ~grant;
    keep     = (state == OWN) && ((grant & req & lock) != 3'b000) &&
               ((hold_cnt < MAXH) || (others == 3'b000));
    scan_ptr = ((state == OWN) && !keep) ? inc3(sel) : ptr;
  end

  // Round-robin scan: first requester at scan_ptr, scan_ptr+1, scan_ptr+2 (mod 3).
  always_comb begin
    req_ext = {1'b0, req};
    win_any = 1'b0;
    win_idx = 2'd3;
    cand    = scan_ptr;
    for (int unsigned k = 0; k < 3; k++) begin
      if (!win_any && req_ext[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
      cand = inc3(cand);
    end
    win_oh = win_any ? (3'b001 << win_idx) : 3'b000;
  end

  // Next-state and registered-output values.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    sel_nxt   = sel;
    busy_nxt  = busy;
    hold_nxt  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (win_any) begin
          state_nxt = OWN;
          grant_nxt = win_oh;
          sel_nxt   = win_idx;
          busy_nxt  = 1'b1;
          hold_nxt  = 4'd1;
        end else begin
          grant_nxt = '0;
          sel_nxt   = '1;
          busy_nxt  = 1'b0;
          hold_nxt  = '0;
        end
      end
      OWN: begin
        if (keep) begin
          if (hold_cnt < MAXH) hold_nxt = hold_cnt + 4'd1;
        end else begin
          ptr_nxt = scan_ptr;
          if (win_any) begin
            grant_nxt = win_oh;
            sel_nxt   = win_idx;
            busy_nxt  = 1'b1;
            hold_nxt  = 4'd1;
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
            sel_nxt   = '1;
            busy_nxt  = 1'b0;
            hold_nxt  = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      sel      <= '1;
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant    <= grant_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic against
// a behavioural owner/pointer model.
module tb_wb_port_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] lock = '0;
  logic [2:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] hold_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner index (-1 = none), rotation pointer, hold count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  wb_port_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
    .grant(grant), .sel(sel), .busy(busy), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
  endfunction

  function automatic void model_edge(input logic [2:0] r, input logic [2:0] l);
    bit found;
    int idx;
    if (m_owner >= 0) begin
      int others = 0;
      for (int i = 0; i < 3; i++) if (i != m_owner && r[i]) others++;
      if (r[m_owner] && l[m_owner] && (m_hold < MAX_HOLD || others == 0)) begin
        if (m_hold < MAX_HOLD) m_hold++;
        return;
      end
      m_ptr = (m_owner + 1) % 3;
    end
    m_owner = -1;
    m_hold  = 0;
    found   = 0;
    for (int k = 0; k < 3; k++) begin
      idx = (m_ptr + k) % 3;
      if (!found && r[idx]) begin
        found   = 1;
        m_owner = idx;
        m_hold  = 1;
      end
    end
  endfunction

  task automatic compare_all();
    int exp_sel;
    check("grant", int'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
    check("sel", int'(sel), (m_owner >= 0) ? m_owner : 3);
    check("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
    check("hold_cnt", int'(hold_cnt), m_hold);
    // Structural checks derived from grant alone.
    check("onehot0", int'($onehot0(grant)), 1);
    case (grant)
      3'b001:  exp_sel = 0;
      3'b010:  exp_sel = 1;
      3'b100:  exp_sel = 2;
      default: exp_sel = 3;
    endcase
    check("sel_vs_grant", int'(sel), exp_sel);
    check("busy_vs_grant", int'(busy), int'(|grant));
    check("hold_le_max", int'(hold_cnt <= 4'(MAX_HOLD)), 1);
  endtask

  // Called at a negedge: drive inputs, take one posedge, compare at the next negedge.
  task automatic step(input logic [2:0] r, input logic [2:0] l);
    req  = r;
    lock = l;
    @(posedge clk);
    model_edge(r, l);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next posedge.
  task automatic async_reset(input logic [2:0] r_during);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_grant", int'(grant), 0);
    check("rst_sel", int'(sel), 3);
    check("rst_busy", int'(busy), 0);
    check("rst_hold", int'(hold_cnt), 0);
    model_reset();
    req  = r_during;
    lock = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] r, l;
    // Power-on reset with all sources requesting.
    req = 3'b111;
    repeat (2) @(negedge clk);
    check("por_grant", int'(grant), 0);
    check("por_sel", int'(sel), 3);
    rst_n = 1'b1;

    // Round robin from ptr = 0, no locks: 001, 010, 100, 001.
    step(3'b111, 3'b000); check("rr0", int'(grant), 1);
    step(3'b111, 3'b000); check("rr1", int'(grant), 2);
    step(3'b111, 3'b000); check("rr2", int'(grant), 4);
    step(3'b111, 3'b000); check("rr3", int'(grant), 1);

    // Lock limit: source 1 holds 1..MAX_HOLD then yields to source 0.
    async_reset(3'b000);
    step(3'b010, 3'b010);
    for (int i = 0; i < MAX_HOLD - 1; i++) step(3'b011, 3'b010);
    check("lock_hold_max", int'(hold_cnt), MAX_HOLD);
    step(3'b011, 3'b010);
    check("lock_release_grant", int'(grant), 1);
    check("lock_release_hold", int'(hold_cnt), 1);

    // Uncontended lock on source 2 for 20 cycles.
    async_reset(3'b000);
    for (int i = 0; i < 20; i++) step(3'b100, 3'b100);
    check("unc_grant", int'(grant), 4);
    check("unc_hold_sat", int'(hold_cnt), MAX_HOLD);

    // Unlocked sole requester is re-granted with hold_cnt = 1.
    step(3'b100, 3'b000); check("sole_hold", int'(hold_cnt), 1);
    step(3'b100, 3'b000); check("sole_grant", int'(grant), 4);

    // Drop: owner 0 drops, source 1 waiting; then everyone drops.
    async_reset(3'b000);
    step(3'b001, 3'b001);
    step(3'b010, 3'b001); check("drop_grant", int'(grant), 2); check("drop_sel", int'(sel), 1);
    step(3'b000, 3'b000); check("idle_grant", int'(grant), 0); check("idle_sel", int'(sel), 3);

    // Async reset while source 1 owns.
    step(3'b010, 3'b000);
    check("pre_rst_grant", int'(grant), 2);
    async_reset(3'b000);

    // Random traffic with occasional mid-run resets.
    for (int i = 0; i < 400; i++) begin
      r = 3'($urandom_range(0, 7));
      l = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) r = r | 3'b011;
      if ($urandom_range(0, 99) == 0) async_reset(r);
      else step(r, l);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
